// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: operation modes and FSM states.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_START = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

endpackage

// File: rtl/dff_en_sync.sv
// Single register bit with clock enable and synchronous active-high reset.
module dff_en_sync #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_BIT;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with load/shift/rotate/ASR and an autonomous
// LSB-first serial transfer mode with busy/done handshake.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] qout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] nxt;
  logic             upd;
  logic [WIDTH-1:0] bit_en;

  always_comb begin
    nxt     = qout;
    upd     = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == ST_XFER) begin
      nxt   = {sin, qout[WIDTH-1:1]};
      upd   = 1'b1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (en) begin
      upd = 1'b1;
      case (mode)
        MODE_LOAD:  nxt = din;
        MODE_SHL:   nxt = {qout[WIDTH-2:0], sin};
        MODE_SHR:   nxt = {sin, qout[WIDTH-1:1]};
        MODE_ROTL:  nxt = {qout[WIDTH-2:0], qout[WIDTH-1]};
        MODE_ROTR:  nxt = {qout[0], qout[WIDTH-1:1]};
        MODE_ASR:   nxt = {qout[WIDTH-1], qout[WIDTH-1:1]};
        MODE_START: begin
          upd     = 1'b0;
          state_d = ST_XFER;
          cnt_d   = CW'(WIDTH);
        end
        default:    upd = 1'b0;
      endcase
    end
  end

  // Only bits whose value actually changes are clocked.
  assign bit_en = upd ? (nxt ^ qout) : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_en_sync #(
      .RESET_BIT(RESET_VALUE[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .en (bit_en[i]),
      .d  (nxt[i]),
      .q  (qout[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign sout = qout[0];
  assign busy = (state_q == ST_XFER);
  assign done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomized and directed self-checking bench for universal_shift_register (WIDTH=8).
module tb_universal_shift_register;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] din = 8'd0;
  logic       sin = 1'b0;
  logic [7:0] qout;
  logic       sout, busy, done;

  universal_shift_register #(
    .WIDTH      (8),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .din (din),
    .sin (sin),
    .qout(qout),
    .sout(sout),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register value, transfer shifts remaining, done flag.
  int mq = 0;
  int mleft = 0;
  bit mdone = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic [2:0] md, input logic [7:0] d,
                     input logic s);
    int nq, nl;
    bit nd;
    rst = r; en = e; mode = md; din = d; sin = s;
    nq = mq; nl = mleft; nd = 1'b0;
    if (r) begin
      nq = 0; nl = 0;
    end else if (mleft > 0) begin
      nq = (mq >> 1) | (int'(s) << 7);
      nl = mleft - 1;
      nd = (nl == 0);
    end else if (e) begin
      case (md)
        3'd1: nq = int'(d);
        3'd2: nq = ((mq << 1) | int'(s)) & 255;
        3'd3: nq = (mq >> 1) | (int'(s) << 7);
        3'd4: nq = ((mq << 1) | (mq >> 7)) & 255;
        3'd5: nq = (mq >> 1) | ((mq & 1) << 7);
        3'd6: nq = (mq >> 1) | (mq & 128);
        3'd7: nl = 8;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    mq = nq; mleft = nl; mdone = nd;
    check("model_qout", 32'(qout), 32'(mq));
    check("model_sout", 32'(sout), 32'(mq & 1));
    check("model_busy", 32'(busy), 32'(mleft > 0));
    check("model_done", 32'(done), 32'(mdone));
  endtask

  initial begin
    logic [7:0] pat;
    int busy_cnt;

    // 1: reset, load, enable gating
    cyc(1, 0, 3'd0, 8'h00, 0);
    check("rst_qout", 32'(qout), 32'h00);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sout", 32'(sout), 0);
    cyc(0, 1, 3'd1, 8'hA5, 0);
    check("load_a5", 32'(qout), 32'hA5);
    cyc(0, 0, 3'd1, 8'hFF, 0);
    check("en0_hold", 32'(qout), 32'hA5);

    // 2: shift / rotate / asr
    cyc(0, 1, 3'd2, 8'h00, 1);
    check("shl", 32'(qout), 32'h4B);
    cyc(0, 1, 3'd1, 8'hA5, 0);
    cyc(0, 1, 3'd3, 8'h00, 0);
    check("shr", 32'(qout), 32'h52);
    cyc(0, 1, 3'd1, 8'h81, 0);
    cyc(0, 1, 3'd4, 8'h00, 0);
    check("rotl", 32'(qout), 32'h03);
    cyc(0, 1, 3'd1, 8'h81, 0);
    cyc(0, 1, 3'd5, 8'h00, 0);
    check("rotr", 32'(qout), 32'hC0);
    cyc(0, 1, 3'd1, 8'h81, 0);
    cyc(0, 1, 3'd6, 8'h00, 0);
    check("asr", 32'(qout), 32'hC0);
    cyc(0, 1, 3'd0, 8'h00, 1);
    check("hold", 32'(qout), 32'hC0);

    // 3: serial transfer of 3C with sin=1
    pat = 8'h3C;
    cyc(0, 1, 3'd1, pat, 1);
    cyc(0, 1, 3'd7, 8'h00, 1);
    check("start_qout", 32'(qout), 32'h3C);
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      check("xfer_sout", 32'(sout), 32'(pat[i]));
      if (busy) busy_cnt++;
      cyc(0, 0, 3'd0, 8'h00, 1);
    end
    check("xfer_busy_cycles", 32'(busy_cnt), 8);
    check("xfer_done", 32'(done), 1);
    check("xfer_busy_off", 32'(busy), 0);
    check("xfer_final", 32'(qout), 32'hFF);
    cyc(0, 0, 3'd0, 8'h00, 0);
    check("done_pulse_end", 32'(done), 0);

    // 4: commands ignored while busy
    cyc(0, 1, 3'd7, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      if (i >= 2 && i <= 5) cyc(0, 1, 3'd1, 8'h00, i[0]);
      else cyc(0, 0, 3'd0, 8'h00, i[0]);
    end
    check("ignore_done", 32'(done), 1);
    check("ignore_qout", 32'(qout), 32'hAA);

    // 5: reset mid-transfer
    cyc(0, 1, 3'd1, 8'h5A, 0);
    cyc(0, 1, 3'd7, 8'h00, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 3'd0, 8'h00, 1);
    cyc(1, 0, 3'd0, 8'h00, 1);
    check("midrst_qout", 32'(qout), 32'h00);
    check("midrst_busy", 32'(busy), 0);
    cyc(0, 0, 3'd0, 8'h00, 0);
    check("midrst_nodone", 32'(done), 0);
    cyc(0, 1, 3'd7, 8'h00, 0);
    busy_cnt = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      if (busy) busy_cnt++;
      cyc(0, 0, 3'd0, 8'h00, 1);
    end
    check("restart_busy_cycles", 32'(busy_cnt), 8);
    check("restart_done", 32'(done), 1);

    // 6: start needs en; back-to-back start in done cycle
    cyc(0, 0, 3'd7, 8'h00, 0);
    check("start_en0", 32'(busy), 0);
    cyc(0, 1, 3'd7, 8'h00, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 3'd0, 8'h00, 0);
    check("b2b_done", 32'(done), 1);
    cyc(0, 1, 3'd7, 8'h00, 1);
    check("b2b_busy", 32'(busy), 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 3'd0, 8'h00, 1);
    check("b2b_final", 32'(qout), 32'hFF);

    // Random traffic against the model
    repeat (600) begin
      cyc(($urandom_range(0, 59) == 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
          8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the fixed 4-bit enable register: a WIDTH-bit register built from per-bit enable flip-flop cells.
- Adds parallel load, left/right shift, rotate, arithmetic shift right, and an autonomous WIDTH-cycle serial-transfer mode with busy/done handshake.
- Used as the datapath/serialiser register in later lab designs, for example serial links and shift-add multipliers.

Parameters:
- WIDTH, 8, register width in bits (must be ≥ 2).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into qout on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  operation enable; sampled only while idle.
- mode  input  3  operation select (encoding below).
- din  input  WIDTH  parallel load data.
- sin  input  1  serial input bit.
- qout  output  WIDTH  register contents.
- sout  output  1  serial output, always equal to qout[0] (combinational from the register).
- busy  output  1  high while a serial transfer is in progress.
- done  output  1  one-cycle pulse after a serial transfer completes.

Behaviour:
- Reset (rst=1 at an edge): qout=RESET_VALUE, busy=0, done=0, transfer counter=0, FSM=IDLE. Reset overrides all other inputs, including mid-transfer.
- FSM states: IDLE and XFER.
- IDLE, en=0: qout holds and mode is ignored.
- IDLE, en=1: the operation takes effect at the next edge (latency 1 cycle). Mode encoding:
  - 000 HOLD: qout unchanged.
  - 001 LOAD: qout=din.
  - 010 SHL: qout={qout[WIDTH-2:0], sin}.
  - 011 SHR: qout={sin, qout[WIDTH-1:1]}.
  - 100 ROTL: qout={qout[WIDTH-2:0], qout[WIDTH-1]}.
  - 101 ROTR: qout={qout[0], qout[WIDTH-1:1]}.
  - 110 ASR: qout={qout[WIDTH-1], qout[WIDTH-1:1]}; sin is ignored.
  - 111 START: FSM goes to XFER, counter=WIDTH, busy=1, qout unchanged at this edge.
- XFER:
  - Each edge performs SHR with sin and decrements the counter.
  - The edge that takes the counter 1→0 returns the FSM to IDLE, clears busy, and sets done=1 for exactly one cycle.
  - busy is high for exactly WIDTH cycles.
  - During busy cycle i (i=0..WIDTH-1), sout presents original bit i (LSB first), and sin is captured into the MSB at that cycle's edge.
  - After completion, qout[j] equals the sin value sampled in busy cycle j.
- en and mode are ignored while busy=1. No queuing: a START issued during busy is lost.
- done is cleared at the next edge whether or not en=1. A new START in the cycle where done=1 is accepted, so transfers can run back-to-back with one idle cycle between them.
- Counter width is $clog2(WIDTH+1).
- No combinational path from inputs to outputs except through the register (sout is derived from qout only).

Decomposition:
- Shared package usr_pkg: 3-bit mode localparams (MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_ASR, MODE_START) and FSM state encoding (ST_IDLE, ST_XFER).
- Sub-module dff_en_sync: a single bit cell with d, en, clk, rst (sync, active-high), and q. It is instantiated WIDTH times via generate.
- The top level contains the next-value mux, the per-bit enable, the FSM, and the counter.

Test Plan (WIDTH=8, RESET_VALUE=0):
1. rst=1 for one edge → qout=00, busy=0, done=0, sout=0. Then LOAD din=A5 with en=1 → qout=A5 after 1 edge. Then en=0, mode=LOAD, din=FF → qout stays A5.
2. From A5: SHL sin=1 → 4B. Reload A5, SHR sin=0 → 52. From 81: ROTL → 03, ROTR → C0, ASR with sin=0 → C0.
3. LOAD 3C, then START, with sin=1 throughout → busy=1 for 8 cycles. sout sequence is 0,0,1,1,1,1,0,0. done=1 for one cycle after the last shift, with busy=0 in that cycle. Final qout=FF.
4. START, then apply mode=LOAD din=00 with en=1 during busy cycles 2–5 → ignored; the transfer completes normally after 8 cycles.
5. START, then assert rst during busy cycle 3 → at that edge qout=00, busy=0, and no done pulse follows. A subsequent START runs a full 8-cycle transfer.
6. START with en=0 → busy stays 0. Back-to-back START asserted in the done cycle → second transfer begins and busy=1 on the following cycle.
